// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg
//   Shared definitions for the dead-time gate driver stage:
//   - register select codes (addr_i[23:16])
//   - CTRL / STATUS bit positions
//   - per-channel state encoding
package pwm_dt_pkg;

  // Register select values, taken from addr_i[23:16].
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_DT0    = 8'h01;
  localparam logic [7:0] REG_DT1    = 8'h02;
  localparam logic [7:0] REG_DT2    = 8'h03;
  localparam logic [7:0] REG_DT3    = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h05;

  // CTRL: [NCH-1:0] channel enables, [8] global kill.
  localparam int CTRL_KILL_BIT = 8;

  // STATUS: [3:0] hs_o, [7:4] ls_o, [11:8] sticky swallowed-pulse flags.
  localparam int STATUS_HS_LSB   = 0;
  localparam int STATUS_LS_LSB   = 4;
  localparam int STATUS_FLAG_LSB = 8;

  // Per-channel state. Only HS_ON drives the high side and only LS_ON
  // drives the low side, so the two can never overlap.
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_LS_ON  = 3'd1,
    ST_DEAD_H = 3'd2,
    ST_HS_ON  = 3'd3,
    ST_DEAD_L = 3'd4
  } chan_state_e;

  // Select code of the dead-time register belonging to channel k.
  function automatic logic [7:0] dt_reg_sel(input int k);
    return REG_DT0 + 8'(k);
  endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if
//   Peripheral bus port of the dead-time stage.
//   Signals: we_i (write strobe), addr_i (register select in [23:16]),
//   data_i (write data), data_o (read data).
//   Handshake: there is no valid/ready pair. A write happens on every
//   clock edge where we_i=1, using addr_i/data_i of that cycle; a read is
//   purely combinational, data_o follows addr_i within the same cycle.
interface pwm_deadtime_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/pwm_dt_chan.sv
// pwm_dt_chan
//   One complementary gate-drive channel: FSM plus dead-time counter.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     pwm        raw PWM level for this channel
//     en, kill   channel enable and global kill (kill wins)
//     dt         dead time in clock cycles (sampled when a dead period starts)
//     hs, ls     high/low side drive, decoded from the state register
//     swallow    one-cycle pulse: a dead period was aborted because pwm
//                returned to its previous level before the period ended
//     state_o    current state, for observation
module pwm_dt_chan
  import pwm_dt_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pwm,
  input  logic            en,
  input  logic            kill,
  input  logic [DT_W-1:0] dt,
  output logic            hs,
  output logic            ls,
  output logic            swallow,
  output chan_state_e     state_o
);

  chan_state_e     state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            dt_zero;

  assign dt_zero = (dt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swallow = 1'b0;

    if (!en || kill) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pwm) begin
            state_d = dt_zero ? ST_HS_ON : ST_DEAD_H;
          end else begin
            state_d = dt_zero ? ST_LS_ON : ST_DEAD_L;
          end
          cnt_d = dt;
        end

        ST_LS_ON: begin
          if (pwm) begin
            state_d = dt_zero ? ST_HS_ON : ST_DEAD_H;
            cnt_d   = dt;
          end
        end

        ST_HS_ON: begin
          if (!pwm) begin
            state_d = dt_zero ? ST_LS_ON : ST_DEAD_L;
            cnt_d   = dt;
          end
        end

        // A dead period ends on the edge where cnt is 1; loading dt at entry
        // therefore gives exactly dt cycles with both sides low. The counter
        // only decrements while it is 2 or more, so it never wraps.
        ST_DEAD_H: begin
          if (!pwm) begin
            state_d = ST_LS_ON;
            swallow = 1'b1;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = ST_HS_ON;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end

        ST_DEAD_L: begin
          if (pwm) begin
            state_d = ST_HS_ON;
            swallow = 1'b1;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = ST_LS_ON;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end

        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  assign hs      = (state_q == ST_HS_ON);
  assign ls      = (state_q == ST_LS_ON);
  assign state_o = state_q;

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
//   Complementary gate driver with programmable dead time for the 4-channel
//   PWM peripheral.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     bus           peripheral bus (we_i/addr_i/data_i/data_o), slave side
//     pwm_i         raw PWM levels, same clock domain
//     hs_o, ls_o    high/low side drives, never both high on one channel
//     dbg_state_o   per-channel FSM state, for observation
//   Registers (addr_i[23:16]): 0x00 CTRL, 0x01..0x04 DT0..DT3, 0x05 STATUS.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_deadtime_if.slave         bus,
  input  logic [NCH-1:0]        pwm_i,
  output logic [NCH-1:0]        hs_o,
  output logic [NCH-1:0]        ls_o,
  output chan_state_e [NCH-1:0] dbg_state_o
);

  logic [7:0]                reg_sel;
  logic [NCH-1:0]            en_q, en_d;
  logic                      kill_q, kill_d;
  logic [NCH-1:0][DT_W-1:0]  dt_q, dt_d;
  logic [NCH-1:0]            flag_q, flag_d;
  logic [NCH-1:0]            swallow;
  logic [NCH-1:0]            flag_clr;

  assign reg_sel = bus.addr_i[23:16];

  // Address and data bits outside the register map are don't-care.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr_i[31:24], bus.addr_i[15:0], bus.data_i[31:12]};

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= '0;
      kill_q <= 1'b0;
      dt_q   <= '0;
      flag_q <= '0;
    end else begin
      en_q   <= en_d;
      kill_q <= kill_d;
      dt_q   <= dt_d;
      flag_q <= flag_d;
    end
  end

  // Register writes.
  always_comb begin
    en_d     = en_q;
    kill_d   = kill_q;
    dt_d     = dt_q;
    flag_clr = '0;
    if (bus.we_i) begin
      if (reg_sel == REG_CTRL) begin
        en_d   = bus.data_i[NCH-1:0];
        kill_d = bus.data_i[CTRL_KILL_BIT];
      end
      if (reg_sel == REG_STATUS) begin
        flag_clr = bus.data_i[STATUS_FLAG_LSB +: NCH];
      end
      for (int k = 0; k < NCH; k++) begin
        if (reg_sel == dt_reg_sel(k)) begin
          dt_d[k] = bus.data_i[DT_W-1:0];
        end
      end
    end
  end

  // Sticky flags: a new swallow event beats a simultaneous clear.
  always_comb begin
    flag_d = (flag_q & ~flag_clr) | swallow;
  end

  // Register reads, combinational from addr_i; forced to zero in reset.
  always_comb begin
    bus.data_o = '0;
    if (!rst) begin
      if (reg_sel == REG_CTRL) begin
        bus.data_o[NCH-1:0]         = en_q;
        bus.data_o[CTRL_KILL_BIT]   = kill_q;
      end
      if (reg_sel == REG_STATUS) begin
        bus.data_o[STATUS_HS_LSB +: NCH]   = hs_o;
        bus.data_o[STATUS_LS_LSB +: NCH]   = ls_o;
        bus.data_o[STATUS_FLAG_LSB +: NCH] = flag_q;
      end
      for (int k = 0; k < NCH; k++) begin
        if (reg_sel == dt_reg_sel(k)) begin
          bus.data_o[DT_W-1:0] = dt_q[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    pwm_dt_chan #(
      .DT_W (DT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .pwm     (pwm_i[k]),
      .en      (en_q[k]),
      .kill    (kill_q),
      .dt      (dt_q[k]),
      .hs      (hs_o[k]),
      .ls      (ls_o[k]),
      .swallow (swallow[k]),
      .state_o (dbg_state_o[k])
    );
  end

endmodule
